// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the 4:1 mux round-robin select controller.
package mux_sel_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sel_state_t;

    // One-hot decode of a channel select.
    function automatic logic [N_CH-1:0] onehot4(input logic [SEL_W-1:0] sel);
        onehot4 = N_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Round-robin priority pick: first requester scanning last+1, last+2, ... (mod 4).
module rr_prio_pick
    import mux_sel_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic             valid,
    output logic [SEL_W-1:0] pick
);

    // Scan from the farthest offset down so the nearest requester after `last` wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        idx   = '0;
        pick  = '0;
        valid = |req;
        for (int k = N_CH; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sel_ctrl.sv
// Round-robin select/enable controller for a 4:1 channel mux with bounded bursts.
// Optional feature: define RR_SEL_LOCK_EN to add a `lock` input that suppresses
// the burst-length release while asserted.
// rst_n is expected to be release-synchronised upstream.
module mux4_rr_sel_ctrl
    import mux_sel_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             out_ready,
`ifdef RR_SEL_LOCK_EN
    input  logic             lock,
`endif
    output logic [SEL_W-1:0] S,
    output logic             E,
    output logic [N_CH-1:0]  gnt,
    output logic             beat,
    output logic [CNT_W-1:0] busy_cnt
);

    sel_state_t       state_q, state_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic             e_q, e_d;
    logic [N_CH-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic             pick_valid;
    logic [SEL_W-1:0] pick;
    logic             hold_lock;
    logic             beat_c;
    logic             hold_hit;
    logic             release_c;

`ifdef RR_SEL_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    // Masking by the current grant keeps a lone re-requester from winning back-to-back;
    // in IDLE gnt_q is zero so the mask is transparent.
    rr_prio_pick u_pick (
        .req   (req & ~gnt_q),
        .last  (last_q),
        .valid (pick_valid),
        .pick  (pick)
    );

    assign beat_c    = e_q & out_ready;
    assign hold_hit  = (busy_cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign release_c = (beat_c & hold_hit & ~hold_lock) | ~req[s_q];

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        e_d        = e_q;
        gnt_d      = gnt_q;
        busy_cnt_d = busy_cnt_q;
        last_d     = last_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    s_d        = pick;
                    e_d        = 1'b1;
                    gnt_d      = onehot4(pick);
                    last_d     = pick;
                    busy_cnt_d = '0;
                end
            end
            GRANT: begin
                if (beat_c && !hold_hit) begin
                    busy_cnt_d = busy_cnt_q + CNT_W'(1);
                end
                if (release_c) begin
                    if (pick_valid) begin
                        s_d        = pick;
                        e_d        = 1'b1;
                        gnt_d      = onehot4(pick);
                        last_d     = pick;
                        busy_cnt_d = '0;
                    end else begin
                        state_d    = IDLE;
                        e_d        = 1'b0;
                        gnt_d      = '0;
                        busy_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                e_d        = 1'b0;
                gnt_d      = '0;
                busy_cnt_d = '0;
            end
        endcase
    end

    // State and output registers; reset drops the grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_q        <= '0;
            e_q        <= 1'b0;
            gnt_q      <= '0;
            busy_cnt_q <= '0;
            last_q     <= SEL_W'(N_CH - 1);
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            e_q        <= e_d;
            gnt_q      <= gnt_d;
            busy_cnt_q <= busy_cnt_d;
            last_q     <= last_d;
        end
    end

    assign S        = s_q;
    assign E        = e_q;
    assign gnt      = gnt_q;
    assign busy_cnt = busy_cnt_q;
    assign beat     = beat_c;

endmodule

// File: tb/tb_mux4_rr_sel_ctrl.sv
// Bench for mux4_rr_sel_ctrl: integer-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mux4_rr_sel_ctrl;

    localparam int unsigned HOLD = 4;
    localparam int unsigned CW   = 8;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req;
    logic          out_ready;
    logic          lock;
    logic [1:0]    S;
    logic          E;
    logic [3:0]    gnt;
    logic          beat;
    logic [CW-1:0] busy_cnt;

    int vectors;
    int miscompares;

    // Reference model state: owner = -1 when nothing is granted.
    int m_owner;
    int m_beats;
    int m_last;
    int m_sel;

    mux4_rr_sel_ctrl #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
`ifdef RR_SEL_LOCK_EN
        .lock      (lock),
`endif
        .S         (S),
        .E         (E),
        .gnt       (gnt),
        .beat      (beat),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First requester after `from`, excluding channel `excl`; -1 if none.
    function automatic int scan(input logic [3:0] r, input int from, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (from + k) % 4;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    // Reference model: who owns the mux and how many beats it has been given.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = 3;
            m_sel   = 0;
        end else if (m_owner < 0) begin
            int nxt;
            nxt = scan(req, m_last, -1);
            if (nxt >= 0) begin
                m_owner = nxt; m_last = nxt; m_sel = nxt; m_beats = 0;
            end
        end else begin
            bit done;
            int nxt;
            done = 1'b0;
            if (out_ready) begin
                m_beats++;
                if (m_beats >= HOLD && !lock) done = 1'b1;
            end
            if (!req[m_owner]) done = 1'b1;
            if (done) begin
                nxt = scan(req, m_last, m_owner);
                if (nxt >= 0) begin
                    m_owner = nxt; m_last = nxt; m_sel = nxt; m_beats = 0;
                end else begin
                    m_owner = -1; m_beats = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int exp_cnt;
        logic exp_e;
        logic [3:0] exp_g;
        exp_e   = (m_owner >= 0);
        exp_g   = exp_e ? (4'b0001 << m_owner) : 4'b0000;
        exp_cnt = (m_beats > int'(HOLD) - 1) ? int'(HOLD) - 1 : m_beats;
        chk("model_E",        32'(E),        32'(exp_e));
        chk("model_S",        32'(S),        32'(m_sel));
        chk("model_gnt",      32'(gnt),      32'(exp_g));
        chk("model_busy_cnt", 32'(busy_cnt), 32'(exp_cnt));
        chk("model_beat",     32'(beat),     32'(exp_e & out_ready));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req         = 4'b0000;
        out_ready   = 1'b0;
        lock        = 1'b0;
        step(2);
        chk("rst_E",   32'(E),        32'd0);
        chk("rst_S",   32'(S),        32'd0);
        chk("rst_gnt", 32'(gnt),      32'd0);
        chk("rst_cnt", 32'(busy_cnt), 32'd0);
        rst_n = 1'b1;

        // 1: lone requester ch0, four beats, one idle cycle, re-grant
        req = 4'b0001; out_ready = 1'b1;
        step(1);
        chk("t1_E",   32'(E),   32'd1);
        chk("t1_S",   32'(S),   32'd0);
        chk("t1_gnt", 32'(gnt), 32'b0001);
        step(3);
        chk("t1_cnt3", 32'(busy_cnt), 32'd3);
        step(1);
        chk("t1_gap_E", 32'(E), 32'd0);
        step(1);
        chk("t1_regrant_E", 32'(E), 32'd1);
        chk("t1_regrant_S", 32'(S), 32'd0);
        req = 4'b0000;
        step(1);
        chk("t1_drop_E", 32'(E), 32'd0);

        // 2: all requesting, grants rotate 0,1,2,3,0 with no E gap
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        step(1);
        for (int g = 0; g < 5; g++) begin
            chk("t2_S", 32'(S), 32'(g % 4));
            for (int c = 0; c < 4; c++) begin
                chk("t2_E", 32'(E), 32'd1);
                step(1);
            end
        end

        // 3: ch2 stalled by out_ready=0 for 10 cycles
        do_reset();
        req = 4'b0100; out_ready = 1'b0;
        step(1);
        chk("t3_S", 32'(S), 32'd2);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t3_stall_cnt", 32'(busy_cnt), 32'd1);
            chk("t3_stall_E",   32'(E),        32'd1);
        end
        out_ready = 1'b1;
        step(1);
        chk("t3_resume_cnt", 32'(busy_cnt), 32'd2);

        // 4: ch1 drops after two beats, ch3 takes over back-to-back
        do_reset();
        req = 4'b0010; out_ready = 1'b1;
        step(1);
        chk("t4_S1", 32'(S), 32'd1);
        step(2);
        chk("t4_cnt2", 32'(busy_cnt), 32'd2);
        req = 4'b1000;
        step(1);
        chk("t4_S3",  32'(S),        32'd3);
        chk("t4_E",   32'(E),        32'd1);
        chk("t4_cnt", 32'(busy_cnt), 32'd0);

        // 5: reset mid-grant drops everything at once; restart scans from ch0
        do_reset();
        req = 4'b0111; out_ready = 1'b1;
        step(3);
        chk("t5_pre_cnt", 32'(busy_cnt), 32'd2);
        req = 4'b0110;
        rst_n = 1'b0;
        #1;
        chk("t5_E",    32'(E),    32'd0);
        chk("t5_S",    32'(S),    32'd0);
        chk("t5_gnt",  32'(gnt),  32'd0);
        chk("t5_beat", 32'(beat), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("t5_first_S", 32'(S), 32'd1);

`ifdef RR_SEL_LOCK_EN
        // 6: lock holds ch0 past the burst limit; unlock releases to ch1
        do_reset();
        lock = 1'b1; req = 4'b0011; out_ready = 1'b1;
        step(1);
        for (int i = 0; i < 20; i++) begin
            chk("t6_lock_S", 32'(S), 32'd0);
            step(1);
        end
        chk("t6_sat_cnt", 32'(busy_cnt), 32'(HOLD - 1));
        lock = 1'b0;
        step(1);
        chk("t6_rel_S", 32'(S), 32'd1);
`endif

        req = 4'b0000;
        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
